// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchroniser per bit feeding a whole-vector debounce FSM.
// Optional macro SWITCH_EDGE_EN adds per-bit rise/fall pulses aligned with changed.

module switch_sync_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clock,
  input  logic n_reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync_pipe; // [0] = sync1, [1] = sync2

  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) sync_pipe <= {2{RST_BIT}};
    else          sync_pipe <= {sync_pipe[0], d};

  assign q = sync_pipe[1];
endmodule

module switch_debouncer #(
  parameter int              WIDTH         = 4,
  parameter int              STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] switch_in,
  output logic [WIDTH-1:0] switch_out,
  output logic             changed,
  output logic             busy
`ifdef SWITCH_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);
  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] s, cand, cand_d, out_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    switch_sync_bit #(.RST_BIT(RESET_VALUE[i])) u_sync (
      .clock   (clock),
      .n_reset (n_reset),
      .d       (switch_in[i]),
      .q       (s[i])
    );
  end

  always_comb begin
    state_d   = state;
    cand_d    = cand;
    cnt_d     = cnt;
    out_d     = switch_out;
    changed_d = 1'b0;
    case (state)
      IDLE:
        if (s != switch_out) begin
          cand_d  = s;
          cnt_d   = CW'(1);
          state_d = COUNT;
        end
      COUNT:
        // A change in s always beats acceptance on the same edge.
        if (s != cand && s == switch_out) begin
          state_d = IDLE;
        end else if (s != cand) begin
          cand_d = s;
          cnt_d  = CW'(1);
        end else if (cnt == CNT_MAX) begin
          out_d     = cand;
          changed_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      state      <= IDLE;
      cand       <= RESET_VALUE;
      cnt        <= '0;
      switch_out <= RESET_VALUE;
      changed    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cand       <= cand_d;
      cnt        <= cnt_d;
      switch_out <= out_d;
      changed    <= changed_d;
      busy       <= (state_d == COUNT);
    end

`ifdef SWITCH_EDGE_EN
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= changed_d ? (cand & ~switch_out) : '0;
      fall <= changed_d ? (~cand & switch_out) : '0;
    end
`endif
endmodule
